// File: rtl/spi_responder.sv
// SPI mode-3 responder with a 40-bit frame (write flag, 7-bit address, 32-bit data) and a
// small register file. The read response is pipelined by one frame.
module spi_responder #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk_in,
  input  logic                        reset_n_in,
  input  logic                        sclk_in,
  input  logic                        cs_n_in,
  input  logic                        serial_in,
  output logic                        serial_out,
  output logic                        serial_oe_out,
  input  logic [7:0]                  status_in,
  output logic                        wr_valid_out,
  output logic [6:0]                  wr_addr_out,
  output logic [31:0]                 wr_data_out,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_in,
  output logic [31:0]                 rd_data_out,
  output logic                        frame_err_out
);

  localparam int unsigned AW       = $clog2(NUM_REGS);
  localparam logic [7:0]  NumRegs8 = 8'(NUM_REGS);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sclk_sync_q, cs_sync_q, sdi_sync_q;
  logic                     sclk_prev_q, cs_prev_q;
  logic [5:0]               cnt_q, cnt_d;
  logic [39:0]              tx_q, tx_d, rx_q, rx_d;
  logic [6:0]               rd_ptr_q, rd_ptr_d;
  logic [31:0]              regs_q [NUM_REGS];
  logic [31:0]              regs_d [NUM_REGS];
  logic                     wr_valid_q, wr_valid_d, frame_err_q, frame_err_d;
  logic [6:0]               wr_addr_q, wr_addr_d;
  logic [31:0]              wr_data_q, wr_data_d;

  logic sclk_s, cs_s, sdi_s, sclk_rise, sclk_fall, cs_fall, load;
  logic [6:0] frame_addr;

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign sclk_fall  = ~sclk_s & sclk_prev_q;
  assign cs_fall    = ~cs_s & cs_prev_q;
  assign frame_addr = rx_q[38:32];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rd_ptr_d    = rd_ptr_q;
    regs_d      = regs_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) load = 1'b1;
      end
      StShift: begin
        if (cs_s) begin
          state_d = StCommit;
        end else begin
          if (sclk_rise) begin
            rx_d  = {rx_q[38:0], sdi_s};
            cnt_d = (cnt_q == 6'd41) ? cnt_q : cnt_q + 6'd1;
          end
          if (sclk_fall && cnt_q != 6'd0) tx_d = {tx_q[38:0], 1'b0};
        end
      end
      StCommit: begin
        state_d = StIdle;
        if (cnt_q == 6'd40) begin
          rd_ptr_d = frame_addr;
          if (rx_q[39]) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = frame_addr;
            wr_data_d  = rx_q[31:0];
            if ({1'b0, frame_addr} < NumRegs8) regs_d[frame_addr[AW-1:0]] = rx_q[31:0];
          end
        end else begin
          frame_err_d = 1'b1;
        end
        // A new frame starting during COMMIT sees this frame's pointer and write.
        if (cs_fall) load = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      state_d = StShift;
      cnt_d   = 6'd0;
      rx_d    = '0;
      tx_d    = {status_in,
                 ({1'b0, rd_ptr_d} < NumRegs8) ? regs_d[rd_ptr_d[AW-1:0]] : 32'd0};
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= StIdle;
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rd_ptr_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], serial_in};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  assign serial_oe_out = (state_q == StShift);
  assign serial_out    = (state_q == StShift) ? tx_q[39] : 1'b0;
  assign wr_valid_out  = wr_valid_q;
  assign wr_addr_out   = wr_addr_q;
  assign wr_data_out   = wr_data_q;
  assign frame_err_out = frame_err_q;
  assign rd_data_out   = regs_q[rd_addr_in];

endmodule

// File: tb/tb_spi_responder.sv
// Randomized bench for spi_responder: drives SPI frames and compares MISO, write pulses,
// error pulses and local readback against a frame-level reference model.
module tb_spi_responder;

  localparam int unsigned NumRegs = 16;
  localparam int unsigned AW      = 4;

  logic          clk_in = 1'b0;
  logic          reset_n_in, sclk_in, cs_n_in, serial_in;
  logic          serial_out, serial_oe_out, wr_valid_out, frame_err_out;
  logic [7:0]    status_in;
  logic [6:0]    wr_addr_out;
  logic [31:0]   wr_data_out, rd_data_out;
  logic [AW-1:0] rd_addr_in;

  spi_responder #(.NUM_REGS(NumRegs), .SYNC_STAGES(2)) dut (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .sclk_in      (sclk_in),
    .cs_n_in      (cs_n_in),
    .serial_in    (serial_in),
    .serial_out   (serial_out),
    .serial_oe_out(serial_oe_out),
    .status_in    (status_in),
    .wr_valid_out (wr_valid_out),
    .wr_addr_out  (wr_addr_out),
    .wr_data_out  (wr_data_out),
    .rd_addr_in   (rd_addr_in),
    .rd_data_out  (rd_data_out),
    .frame_err_out(frame_err_out)
  );

  always #20 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: register contents, read pointer, expected write/error events.
  logic [31:0] mdl_regs [NumRegs];
  int unsigned mdl_ptr = 0;
  logic [38:0] exp_wr_q [$];
  int exp_wr_total = 0, exp_err = 0, seen_wr = 0, seen_err = 0;

  function automatic logic [31:0] mdl_read(input int unsigned a);
    return (a < NumRegs) ? mdl_regs[a] : 32'd0;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < NumRegs; i++) mdl_regs[i] = 32'd0;
    mdl_ptr = 0;
  endtask

  always @(negedge clk_in) begin : monitor
    logic [38:0] e;
    if (wr_valid_out) begin
      seen_wr++;
      if (exp_wr_q.size() == 0) begin
        check("wr_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_wr_q.pop_front();
        check("wr_addr", 64'(wr_addr_out), 64'(e[38:32]));
        check("wr_data", 64'(wr_data_out), 64'(e[31:0]));
      end
    end
    if (frame_err_out) seen_err++;
  end

  task automatic check_rd(input int unsigned a);
    rd_addr_in = AW'(a);
    @(negedge clk_in);
    check("rd_data", 64'(rd_data_out), 64'(mdl_read(a)));
  endtask

  // nbits sclk cycles at 8 clk_in per period; rst_at >= 0 aborts with reset before that bit.
  task automatic spi_frame(input logic [39:0] mosi, input logic [7:0] status, input int nbits,
                           input int gap, input int rst_at);
    logic [39:0] miso, exp_miso, mask;
    bit aborted;
    miso     = '0;
    aborted  = 1'b0;
    exp_miso = {status, mdl_read(mdl_ptr)};
    @(negedge clk_in);
    status_in = status;
    cs_n_in   = 1'b0;
    repeat (6) @(negedge clk_in);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        aborted = 1'b1;
        break;
      end
      sclk_in   = 1'b0;
      serial_in = mosi[39-i];
      repeat (4) @(negedge clk_in);
      if (i == 0) check("miso_oe", 64'(serial_oe_out), 64'd1);
      miso    = {miso[38:0], serial_out};
      sclk_in = 1'b1;
      repeat (4) @(negedge clk_in);
    end
    if (aborted) begin
      reset_n_in = 1'b0;
      @(negedge clk_in);
      check("rst_oe", 64'(serial_oe_out), 64'd0);
      check("rst_sout", 64'(serial_out), 64'd0);
      check("rst_wr_valid", 64'(wr_valid_out), 64'd0);
      check("rst_wr_addr", 64'(wr_addr_out), 64'd0);
      check("rst_wr_data", 64'(wr_data_out), 64'd0);
      check("rst_frame_err", 64'(frame_err_out), 64'd0);
      check("rst_rd_data", 64'(rd_data_out), 64'd0);
      cs_n_in   = 1'b1;
      sclk_in   = 1'b1;
      serial_in = 1'b0;
      repeat (3) @(negedge clk_in);
      reset_n_in = 1'b1;
      mdl_reset();
      repeat (gap) @(negedge clk_in);
      return;
    end
    cs_n_in = 1'b1;
    mask    = (40'd1 << nbits) - 40'd1;
    check("miso", 64'(miso & mask), 64'(exp_miso >> (40 - nbits)));
    if (nbits == 40) begin
      mdl_ptr = int'(mosi[38:32]);
      if (mosi[39]) begin
        exp_wr_q.push_back(mosi[38:0]);
        exp_wr_total++;
        if (mosi[38:32] < NumRegs) mdl_regs[mosi[38:32]] = mosi[31:0];
      end
    end else begin
      exp_err++;
    end
    repeat (gap) @(negedge clk_in);
  endtask

  initial begin
    int unsigned addr, nb, gp;
    reset_n_in = 1'b0;
    sclk_in    = 1'b1;
    cs_n_in    = 1'b1;
    serial_in  = 1'b0;
    status_in  = 8'h00;
    rd_addr_in = '0;
    mdl_reset();
    repeat (3) @(negedge clk_in);
    check("reset_oe", 64'(serial_oe_out), 64'd0);
    check("reset_sout", 64'(serial_out), 64'd0);
    check("reset_wr_valid", 64'(wr_valid_out), 64'd0);
    check("reset_wr_addr", 64'(wr_addr_out), 64'd0);
    check("reset_wr_data", 64'(wr_data_out), 64'd0);
    check("reset_frame_err", 64'(frame_err_out), 64'd0);
    check("reset_rd_data", 64'(rd_data_out), 64'd0);
    reset_n_in = 1'b1;
    repeat (3) @(negedge clk_in);

    // Directed: write, pipelined reads, short frame, out-of-range write.
    spi_frame({1'b1, 7'h02, 32'hDEADBEEF}, 8'h33, 40, 10, -1);
    rd_addr_in = AW'(2);
    @(negedge clk_in);
    check("rd_reg2", 64'(rd_data_out), 64'hDEADBEEF);
    spi_frame({1'b0, 7'h02, 32'h0}, 8'h5A, 40, 10, -1);
    spi_frame({1'b0, 7'h00, 32'h0}, 8'h5A, 40, 10, -1);
    spi_frame({1'b1, 7'h05, 32'h12345678}, 8'hA5, 24, 10, -1);
    check_rd(5);
    spi_frame({1'b0, 7'h02, 32'h0}, 8'h11, 40, 10, -1);
    spi_frame({1'b1, 7'h7F, 32'hCAFEF00D}, 8'h22, 40, 10, -1);
    spi_frame({1'b0, 7'h01, 32'h0}, 8'h44, 40, 10, -1);

    // Reset mid-frame, then a normal write.
    spi_frame({1'b1, 7'h03, 32'h11112222}, 8'h66, 40, 10, 20);
    spi_frame({1'b1, 7'h03, 32'h33334444}, 8'h77, 40, 10, -1);
    check_rd(3);
    check_rd(2);

    // Back-to-back frames with a two-cycle chip-select gap.
    spi_frame({1'b1, 7'h04, 32'hA5A5A5A5}, 8'h88, 40, 2, -1);
    spi_frame({1'b1, 7'h05, 32'h5A5A5A5A}, 8'h99, 40, 10, -1);
    check_rd(4);
    check_rd(5);

    for (int k = 0; k < 40; k++) begin
      addr = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 127) : $urandom_range(0, 15);
      nb   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 39) : 40;
      gp   = $urandom_range(2, 12);
      spi_frame({1'($urandom_range(0, 1)), 7'(addr), 32'($urandom)}, 8'($urandom),
                int'(nb), int'(gp), -1);
      if (gp >= 6) check_rd($urandom_range(0, 15));
    end

    repeat (20) @(negedge clk_in);
    check("wr_count", 64'(seen_wr), 64'(exp_wr_total));
    check("err_count", 64'(seen_err), 64'(exp_err));
    check("wr_pending", 64'(exp_wr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameter NUM_REGS, default 16, SHALL set the register count; it is a power of two, 2..128.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on sclk_in, cs_n_in and serial_in; minimum 2.
REQ-003 clk_in  input  1  SHALL be the system clock (25 MHz on board); all logic is on its rising edge.
REQ-004 reset_n_in  input  1  SHALL be the reset, asynchronous, active-low.
REQ-005 sclk_in  input  1  SHALL be the SPI clock from the initiator, mode 3 (idle high).
REQ-006 cs_n_in  input  1  SHALL be the chip select, active-low.
REQ-007 serial_in  input  1  SHALL be initiator-to-responder data (MOSI).
REQ-008 serial_out  output  1  SHALL be responder-to-initiator data (MISO).
REQ-009 serial_oe_out  output  1  SHALL be high while serial_out is driven.
REQ-010 status_in  input  8  SHALL be the status byte returned at the start of each frame.
REQ-011 wr_valid_out  output  1  SHALL pulse high for one clk_in cycle per committed write.
REQ-012 wr_addr_out  output  7  SHALL be the committed write address, valid with wr_valid_out.
REQ-013 wr_data_out  output  32  SHALL be the committed write data, valid with wr_valid_out.
REQ-014 rd_addr_in  input  log2(NUM_REGS)  SHALL select a register for local readback.
REQ-015 rd_data_out  output  32  SHALL be the register at rd_addr_in, combinational.
REQ-016 frame_err_out  output  1  SHALL pulse high for one clk_in cycle per aborted frame.

Function
REQ-017 Inputs SHALL pass SYNC_STAGES flops; edges detected on synchronized values; sclk_in period is at least 8 clk_in cycles.
REQ-018 Frame SHALL be 40 bits, MSB first: bit 39 = write flag, bits 38:32 = address, bits 31:0 = data.
REQ-019 States SHALL be IDLE, SHIFT, COMMIT; IDLE->SHIFT on cs_n falling, SHIFT->COMMIT on cs_n rising, COMMIT->IDLE after one cycle.
REQ-020 On cs_n falling, the tx shift register SHALL load {status_in, regs[rd_ptr]}, bit counter clears to 0.
REQ-021 In SHIFT, each sclk rising edge SHALL shift serial_in into the rx register LSB-first-in and increment the counter, saturating at 41.
REQ-022 serial_out SHALL equal tx[39] from load; each sclk falling edge with counter > 0 SHALL shift tx left one bit.
REQ-023 serial_oe_out SHALL be high in SHIFT only; serial_out SHALL be 0 when not in SHIFT.
REQ-024 In COMMIT with counter = 40: if write flag = 1 and address < NUM_REGS, regs[address] SHALL take rx data and wr_valid_out pulses.
REQ-025 Write flag = 1 with address >= NUM_REGS SHALL still pulse wr_valid_out but not modify any register.
REQ-026 In COMMIT with counter = 40, rd_ptr SHALL take the frame address (both reads and writes); reads of address >= NUM_REGS return 0 next frame.
REQ-027 In COMMIT with counter != 40, no register, rd_ptr or wr_* output SHALL change; frame_err_out pulses.
REQ-028 Response data SHALL therefore always be the register addressed by the previous valid frame (one-frame read pipeline).
REQ-029 cs_n falling while in COMMIT SHALL be honoured: COMMIT completes, then SHIFT is entered the next cycle with load per REQ-020.
REQ-030 sclk edges while cs_n high SHALL be ignored.

Reset
REQ-031 Reset SHALL force IDLE, counter 0, tx/rx 0, rd_ptr 0, all registers 0, serial_out 0, serial_oe_out 0, wr_valid_out 0, wr_addr_out 0, wr_data_out 0, frame_err_out 0, synchronizers to idle (sclk 1, cs_n 1, data 0).
REQ-032 Reset asserted mid-frame SHALL discard the frame; no write or error pulse is produced; the first frame after release is handled normally.

Verification
REQ-033 Write frame 0x82_DEADBEEF at 3.125 MHz -> one wr_valid_out pulse, wr_addr_out 0x02, wr_data_out 0xDEADBEEF; rd_addr_in 2 gives 0xDEADBEEF.
REQ-034 Then read frame 0x02_00000000 with status_in 0x5A, then 0x00_00000000 -> second frame's MISO = 0x5A_DEADBEEF; first frame's MISO data = 0xDEADBEEF (previous write set rd_ptr 2).
REQ-035 Frame of 24 clocks with write flag set -> frame_err_out pulse, no wr_valid_out, registers and rd_ptr unchanged.
REQ-036 Write to address 0x7F (NUM_REGS 16) -> wr_valid_out pulse with addr 0x7F, no register change; next frame returns data 0.
REQ-037 reset_n_in low after bit 20 of a write frame -> all outputs reset values, no pulses; next full write frame commits normally.
REQ-038 Back-to-back frames with cs_n high for 2 clk_in cycles -> both frames commit, no frame_err_out.
